// File: rtl/serial_adder_n.sv
// Digit-serial add/subtract unit: WIDTH-bit operands are processed DIGIT bits per clock,
// LSB digit first, with a registered carry between digits and valid/ready on both sides.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(N - 1);
    localparam logic [WIDTH-1:0] DIG_MASK = WIDTH'({DIGIT{1'b1}});

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;

    logic [31:0]      shamt;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT-1:0] s_dig;
    logic             c_chain;
    logic             c_msb;
    logic             c_out;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

    assign shamt = 32'(cnt) * 32'(DIGIT);
    assign a_dig = DIGIT'(a_r >> shamt);
    assign b_dig = DIGIT'(b_r >> shamt);

    // Ripple through the digit; c_msb ends up as the carry into the digit's top bit,
    // which on the last digit is the carry into the operand MSB.
    always_comb begin
        c_chain = carry;
        c_msb   = carry;
        s_dig   = '0;
        for (int i = 0; i < DIGIT; i++) begin
            c_msb = c_chain;
            {c_chain, s_dig[i]} = full_add(a_dig[i], b_dig[i], c_chain);
        end
        c_out = c_chain;
    end

    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            carry <= 1'b0;
            a_r   <= '0;
            b_r   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Subtraction as a + ~b + ~cin, so one adder serves both modes.
                        a_r   <= a;
                        b_r   <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum   <= (sum & ~(DIG_MASK << shamt)) | (WIDTH'(s_dig) << shamt);
                    carry <= c_out;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        cout  <= c_out;
                        ovf   <= c_msb ^ c_out;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed and randomized checks of serial_adder_n at WIDTH=8 with DIGIT=1, 4 and 8,
// each instance driven through its own handshake signals.
module tb_serial_adder_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] a, b;
    logic       cin, sub;

    logic       in_valid  [3];
    logic       out_ready [3];
    logic       in_ready  [3];
    logic       out_valid [3];
    logic       cout      [3];
    logic       ovf       [3];
    logic [7:0] sum       [3];

    int checks = 0;
    int errors = 0;
    int lat_tab [3];

    serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0])
    );

    serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1])
    );

    serial_adder_n #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One full transaction on instance k; hold = cycles to stall in DONE while
    // in_valid and the operands are wiggled.
    task automatic run_op(input int k, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tc, input logic ts, input logic [7:0] es,
                          input logic ec, input logic eo, input int hold, input string tag);
        int cyc;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready[k]), 1);
        a = ta; b = tb_v; cin = tc; sub = ts;
        in_valid[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        cyc = 0;
        while (out_valid[k] !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 32'(cyc), 32'(lat_tab[k]));
        for (int i = 0; i < hold; i++) begin
            check({tag, "_bp_vld"},  32'(out_valid[k]), 1);
            check({tag, "_bp_rdy"},  32'(in_ready[k]), 0);
            check({tag, "_bp_sum"},  32'(sum[k]), 32'(es));
            check({tag, "_bp_cout"}, 32'(cout[k]), 32'(ec));
            check({tag, "_bp_ovf"},  32'(ovf[k]), 32'(eo));
            in_valid[k] = ~in_valid[k];
            a = ~a; b = b + 8'h35; cin = ~cin; sub = ~sub;
            @(negedge clk);
        end
        in_valid[k] = 1'b0;
        check({tag, "_vld"},  32'(out_valid[k]), 1);
        check({tag, "_sum"},  32'(sum[k]), 32'(es));
        check({tag, "_cout"}, 32'(cout[k]), 32'(ec));
        check({tag, "_ovf"},  32'(ovf[k]), 32'(eo));
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
        check({tag, "_done_vld"}, 32'(out_valid[k]), 0);
        check({tag, "_done_rdy"}, 32'(in_ready[k]), 1);
        check({tag, "_keep_sum"}, 32'(sum[k]), 32'(es));
    endtask

    task automatic directed(input int k);
        run_op(k, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 0, "add_0f_01");
        run_op(k, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 0, "add_ff_01_c");
        run_op(k, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0, "add_7f_01");
        run_op(k, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 0, "sub_05_07");
        run_op(k, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 0, "sub_80_01");
    endtask

    task automatic random_ops(input int k, input int count);
        logic [7:0] ra, rb, beff;
        logic       rc, rs, ceff, eo;
        logic [8:0] full;
        for (int i = 0; i < count; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rc   = 1'($urandom);
            rs   = 1'($urandom);
            beff = rs ? ~rb : rb;
            ceff = rs ? ~rc : rc;
            full = {1'b0, ra} + {1'b0, beff} + {8'b0, ceff};
            eo   = (ra[7] == beff[7]) && (full[7] != ra[7]);
            run_op(k, ra, rb, rc, rs, full[7:0], full[8], eo,
                   int'($urandom_range(0, 3)), "rand");
        end
    endtask

    initial begin
        int pulses;
        lat_tab[0] = 8; lat_tab[1] = 2; lat_tab[2] = 1;
        rst_n = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("rst_in_ready",  32'(in_ready[k]), 0);
            check("rst_out_valid", 32'(out_valid[k]), 0);
            check("rst_sum",       32'(sum[k]), 0);
            check("rst_cout",      32'(cout[k]), 0);
            check("rst_ovf",       32'(ovf[k]), 0);
        end
        rst_n = 1'b1;

        for (int k = 0; k < 3; k++) directed(k);

        // Backpressure: stall 5 clocks in DONE while toggling inputs
        run_op(0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 5, "bp_d1");
        run_op(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 5, "bp_d4");

        // Reset four clocks into RUN on the DIGIT=1 instance
        @(negedge clk);
        a = 8'hFF; b = 8'h00; cin = 1'b0; sub = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_sum",   32'(sum[0]), 0);
        check("mid_rst_vld",   32'(out_valid[0]), 0);
        check("mid_rst_rdy",   32'(in_ready[0]), 0);
        check("mid_rst_cout",  32'(cout[0]), 0);
        check("mid_rst_ovf",   32'(ovf[0]), 0);
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid[0] === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid[0] !== 1'b0) pulses++;
        end
        check("mid_rst_no_pulse", 32'(pulses), 0);
        run_op(0, 8'h3C, 8'h44, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 0, "post_rst");

        random_ops(0, 200);
        random_ops(1, 1000);
        random_ops(2, 1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
